// File: rtl/ita_mask_apply_if.sv
// Valid/ready stream carrying one beat of packed signed lanes.
//
// Signals:
//   valid  producer has a beat on data
//   ready  consumer takes the beat when valid & ready
//   data   W-bit beat payload
//
// Modports:
//   master  producer side (drives valid/data, observes ready)
//   slave   consumer side (observes valid/data, drives ready)
interface ita_mask_apply_if #(
    parameter int unsigned W = 128
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ita_mask_apply.sv
// Applies attention masks to requantized QK beats on their way to softmax.
// Masks arrive ahead of the data into a small in-order FIFO; each accepted
// beat consumes the head mask, masked lanes are forced to the most negative
// value, and the beat is forwarded through a one-deep output register.
// A per-row running maximum is kept over the column groups of a tile and
// reported once each row completes.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   clear_i           synchronous flush (FIFO, beat counter, row maxima, error)
//   mask_en_i         1: apply masks, 0: bypass (FIFO filled but never popped)
//   mask_valid_i      push strobe for mask_i
//   mask_i            N-bit lane mask, bit i=1 masks lane i
//   in_s              input beat stream (slave)
//   out_m             output beat stream (master)
//   rowmax_valid_o    one-cycle pulse, rowmax_o/rowmax_idx_o final
//   rowmax_o          signed maximum of the completed row
//   rowmax_idx_o      row index within the tile
//   overflow_o        sticky: mask dropped because FIFO full and not popping
module ita_mask_apply #(
    parameter int unsigned N      = 16,
    parameter int unsigned M      = 64,
    parameter int unsigned WO     = 8,
    parameter int unsigned MDEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  mask_en_i,
    input  logic                  mask_valid_i,
    input  logic [N-1:0]          mask_i,
    ita_mask_apply_if.slave       in_s,
    ita_mask_apply_if.master      out_m,
    output logic                  rowmax_valid_o,
    output logic signed [WO-1:0]  rowmax_o,
    output logic [$clog2(M)-1:0]  rowmax_idx_o,
    output logic                  overflow_o
);

    localparam int unsigned BEATS  = M * M / N;
    localparam int unsigned GROUPS = M / N;
    localparam int unsigned IW     = $clog2(BEATS);
    localparam int unsigned RW     = $clog2(M);
    localparam int unsigned GW     = IW - RW;
    localparam int unsigned PW     = $clog2(MDEPTH);
    localparam int unsigned CW     = PW + 1;

    localparam logic signed [WO-1:0] MIN_VAL = {1'b1, {(WO-1){1'b0}}};

    // Mask FIFO
    logic [N-1:0]  fifo_mem [MDEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full;
    logic          fifo_nonempty;
    logic [N-1:0]  head;
    logic          pop;
    logic          push_ok;

    // Datapath
    logic                 valid_q;
    logic [N*WO-1:0]      data_q;
    logic                 accept;
    logic [N*WO-1:0]      masked_beat;
    logic signed [WO-1:0] beat_max;
    logic [IW-1:0]        idx;
    logic [RW-1:0]        row;
    logic [GW-1:0]        grp;
    logic signed [WO-1:0] rmax [M];
    logic signed [WO-1:0] prev_max;
    logic signed [WO-1:0] row_final;

    assign fifo_full     = (fifo_cnt == CW'(MDEPTH));
    assign fifo_nonempty = (fifo_cnt != '0);
    assign head          = fifo_mem[rd_ptr];

    assign in_s.ready = (~mask_en_i | fifo_nonempty) & (~valid_q | out_m.ready);
    assign accept     = in_s.valid & in_s.ready;
    assign pop        = accept & mask_en_i;
    // When full, a push is only taken if the head leaves in the same cycle;
    // the slot being overwritten is the one being popped.
    assign push_ok    = mask_valid_i & (~fifo_full | pop);

    assign out_m.valid = valid_q;
    assign out_m.data  = data_q;

    assign row = idx[RW-1:0];
    assign grp = idx[IW-1:RW];

    always_comb begin : lane_mask
        logic signed [WO-1:0] lane;
        lane        = '0;
        masked_beat = '0;
        beat_max    = MIN_VAL;
        for (int i = 0; i < int'(N); i++) begin
            lane = (mask_en_i & head[i]) ? MIN_VAL : in_s.data[i*WO +: WO];
            masked_beat[i*WO +: WO] = lane;
            if (lane > beat_max) begin
                beat_max = lane;
            end
        end
    end

    always_comb begin
        prev_max  = rmax[row];
        row_final = beat_max;
        if (grp != '0 && prev_max > beat_max) begin
            row_final = prev_max;
        end
    end

    // Mask storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push_ok & ~clear_i) begin
            fifo_mem[wr_ptr] <= mask_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            fifo_cnt       <= '0;
            overflow_o     <= 1'b0;
            valid_q        <= 1'b0;
            data_q         <= '0;
            idx            <= '0;
            rowmax_valid_o <= 1'b0;
            rowmax_o       <= '0;
            rowmax_idx_o   <= '0;
            for (int r = 0; r < int'(M); r++) begin
                rmax[r] <= '0;
            end
        end else if (clear_i) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            fifo_cnt       <= '0;
            overflow_o     <= 1'b0;
            valid_q        <= 1'b0;
            idx            <= '0;
            rowmax_valid_o <= 1'b0;
            for (int r = 0; r < int'(M); r++) begin
                rmax[r] <= '0;
            end
        end else begin
            rowmax_valid_o <= 1'b0;

            if (accept) begin
                valid_q   <= 1'b1;
                data_q    <= masked_beat;
                idx       <= (idx == IW'(BEATS - 1)) ? '0 : idx + IW'(1);
                rmax[row] <= row_final;
                if (grp == GW'(GROUPS - 1)) begin
                    rowmax_valid_o <= 1'b1;
                    rowmax_o       <= row_final;
                    rowmax_idx_o   <= row;
                end
            end else if (out_m.ready) begin
                valid_q <= 1'b0;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (mask_valid_i & fifo_full & ~pop) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ita_mask_apply.sv
module tb_ita_mask_apply;
    localparam int N      = 16;
    localparam int M      = 64;
    localparam int WO     = 8;
    localparam int MDEPTH = 4;
    localparam int BEATS  = M * M / N;
    localparam int GROUPS = M / N;
    localparam int W      = N * WO;
    localparam int MINV   = -(1 << (WO - 1));

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 clear_i;
    logic                 mask_en_i;
    logic                 mask_valid_i;
    logic [N-1:0]         mask_i;
    logic                 rowmax_valid_o;
    logic signed [WO-1:0] rowmax_o;
    logic [5:0]           rowmax_idx_o;
    logic                 overflow_o;

    ita_mask_apply_if #(.W(W)) in_if ();
    ita_mask_apply_if #(.W(W)) out_if ();

    ita_mask_apply #(.N(N), .M(M), .WO(WO), .MDEPTH(MDEPTH)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (clear_i),
        .mask_en_i      (mask_en_i),
        .mask_valid_i   (mask_valid_i),
        .mask_i         (mask_i),
        .in_s           (in_if),
        .out_m          (out_if),
        .rowmax_valid_o (rowmax_valid_o),
        .rowmax_o       (rowmax_o),
        .rowmax_idx_o   (rowmax_idx_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state
    logic [N-1:0] mq[$];
    logic [W-1:0] exp_q[$];
    int           rq_row[$];
    int           rq_val[$];
    int           mat[M][M];
    int           m_idx;
    bit           m_valid;
    bit           m_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic logic [W-1:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: drive, check control outputs, advance the model at the edge.
    task automatic step(input bit v, input logic [W-1:0] d, input bit mv, input logic [N-1:0] m,
                        input bit en, input bit rdy, input bit clr, output bit acc);
        bit           m_ready;
        logic [N-1:0] hd;
        logic [W-1:0] eb;
        int           lv, row, g, mx;
        logic [WO-1:0] lv8;
        in_if.valid  = v;
        in_if.data   = d;
        mask_valid_i = mv;
        mask_i       = m;
        mask_en_i    = en;
        out_if.ready = rdy;
        clear_i      = clr;
        @(negedge clk_i);
        m_ready = (!en || mq.size() > 0) && (!m_valid || rdy);
        check("ctl{ready,valid,ovf}", {in_if.ready, out_if.valid, overflow_o}, {m_ready, m_valid, m_ovf});
        @(posedge clk_i);
        acc = 1'b0;
        if (clr) begin
            mq.delete();
            exp_q.delete();
            m_ovf   = 1'b0;
            m_valid = 1'b0;
            m_idx   = 0;
        end else begin
            acc = v && m_ready;
            hd  = (mq.size() > 0) ? mq[0] : '0;
            if (acc) begin
                row = m_idx % M;
                g   = m_idx / M;
                eb  = '0;
                for (int i = 0; i < N; i++) begin
                    if (en && hd[i]) lv = MINV;
                    else lv = $signed(d[i*WO +: WO]);
                    lv8 = lv[WO-1:0];
                    eb[i*WO +: WO] = lv8;
                    mat[row][g*N + i] = lv;
                end
                exp_q.push_back(eb);
                if (g == GROUPS - 1) begin
                    mx = mat[row][0];
                    for (int c = 1; c < M; c++) if (mat[row][c] > mx) mx = mat[row][c];
                    rq_row.push_back(row);
                    rq_val.push_back(mx);
                end
                m_idx = (m_idx + 1) % BEATS;
                if (en) void'(mq.pop_front());
            end
            if (mv) begin
                if (mq.size() < MDEPTH) mq.push_back(m);
                else m_ovf = 1'b1;
            end
            if (acc) m_valid = 1'b1;
            else if (rdy) m_valid = 1'b0;
        end
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents output.
    bit           hold_pending = 1'b0;
    logic [W-1:0] hold_data;
    always @(negedge clk_i) begin
        if (rst_i) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending && out_if.valid) check("hold_stable", out_if.data, hold_data);
            if (out_if.valid && out_if.ready) begin
                check("beat_expected", W'(exp_q.size() != 0), W'(1));
                if (exp_q.size() != 0) check("beat_data", out_if.data, exp_q.pop_front());
            end
            hold_pending = out_if.valid && !out_if.ready;
            hold_data    = out_if.data;
            if (rowmax_valid_o) begin
                check("rowmax_expected", W'(rq_val.size() != 0), W'(1));
                if (rq_val.size() != 0) begin
                    logic [WO-1:0] ev;
                    int            er, evi;
                    er  = rq_row.pop_front();
                    evi = rq_val.pop_front();
                    ev  = evi[WO-1:0];
                    check("rowmax{idx,val}", {rowmax_idx_o, rowmax_o}, {er[5:0], ev});
                end
            end
        end
    end

    function automatic logic [N-1:0] gen_mask(input int mode, input int k);
        logic [N-1:0] mk;
        int           r, g;
        r  = k % M;
        g  = (k / M) % GROUPS;
        mk = '0;
        case (mode)
            1: for (int i = 0; i < N; i++) mk[i] = (g*N + i > r);
            2: begin
                if (r % 8 == 3) mk = '1;
                else if (r % 8 == 5) begin
                    mk = '1;
                    if (g == 2) mk[7] = 1'b0;
                end else mk = N'($urandom);
            end
            default: mk = N'($urandom);
        endcase
        return mk;
    endfunction

    function automatic logic [W-1:0] gen_data(input int mode, input int k);
        logic [W-1:0] dd;
        int           r, lv;
        r  = k % M;
        dd = rand_beat();
        case (mode)
            0: for (int i = 0; i < N; i++) begin lv = i - 8; dd[i*WO +: WO] = lv[WO-1:0]; end
            1: for (int i = 0; i < N; i++) dd[i*WO +: WO] = 8'h05;
            2: if (r % 8 == 5) dd[7*WO +: WO] = 8'hFD;
            default: ;
        endcase
        return dd;
    endfunction

    // Stream nbeats beats; masks are pushed ahead while the FIFO has room.
    task automatic run_stream(input int nbeats, input bit en, input int mode, input bit rnd, input int stall_at);
        int           p, a, cyc;
        bit           acc, mv, v, rdy;
        logic [W-1:0] cur_d;
        p = 0; a = 0; cyc = 0;
        cur_d = gen_data(mode, 0);
        while (a < nbeats && cyc < nbeats * 6 + 50) begin
            mv  = en && p < nbeats && mq.size() < MDEPTH;
            v   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (cyc >= stall_at && cyc < stall_at + 3) rdy = 1'b0;
            step(v, cur_d, mv, gen_mask(mode, p), en, rdy, 1'b0, acc);
            if (mv) p++;
            if (acc) begin
                a++;
                cur_d = gen_data(mode, a);
            end
            cyc++;
        end
        check("stream_complete", W'(a), W'(nbeats));
    endtask

    initial begin
        bit acc;
        bit en;
        m_idx = 0; m_valid = 0; m_ovf = 0;
        rst_i = 1'b1; clear_i = 0; mask_en_i = 0; mask_valid_i = 0; mask_i = '0;
        in_if.valid = 0; in_if.data = '0; out_if.ready = 1;
        #1;
        check("reset_ctl", {out_if.valid, rowmax_valid_o, rowmax_o, rowmax_idx_o, overflow_o}, '0);
        check("reset_data", out_if.data, '0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Bypass, lane i = i-8; rows complete in beats 192..255 with max 7
        run_stream(BEATS, 1'b0, 0, 1'b0, -10);
        // Upper-triangular mask with a 3-cycle downstream stall
        run_stream(BEATS, 1'b1, 1, 1'b0, 100);
        // Fully masked rows and single-survivor rows
        run_stream(BEATS, 1'b1, 2, 1'b0, -10);
        for (int i = 0; i < 3; i++) step(0, '0, 0, '0, 1, 1, 0, acc);

        // Starvation: valid with empty FIFO stalls; a push is usable next cycle
        step(0, '0, 0, '0, 1, 1, 1, acc);
        for (int i = 0; i < 3; i++) step(1, rand_beat(), 0, '0, 1, 1, 0, acc);
        step(1, rand_beat(), 1, N'($urandom), 1, 1, 0, acc);
        step(1, rand_beat(), 0, '0, 1, 1, 0, acc);
        step(0, '0, 0, '0, 1, 1, 0, acc);

        // Overflow: MDEPTH+1 pushes without pops, then clear empties everything
        step(0, '0, 0, '0, 1, 1, 1, acc);
        for (int i = 0; i < MDEPTH + 1; i++) step(0, '0, 1, N'($urandom), 1, 1, 0, acc);
        step(0, '0, 0, '0, 1, 1, 0, acc);
        step(0, '0, 0, '0, 1, 1, 1, acc);
        step(1, rand_beat(), 0, '0, 1, 1, 0, acc);
        step(0, '0, 0, '0, 1, 1, 0, acc);

        // Random traffic with mode changes and occasional clears
        en = 1'b1;
        for (int c = 0; c < 1200; c++) begin
            if (c % 200 == 0) en = ($urandom_range(0, 2) != 0);
            step($urandom_range(0, 3) != 0, rand_beat(), $urandom_range(0, 2) == 0, N'($urandom),
                 en, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, acc);
        end

        // Asynchronous reset mid-tile with a stalled output beat held
        step(0, '0, 0, '0, 0, 1, 1, acc);
        run_stream(100, 1'b0, 3, 1'b0, -10);
        step(0, '0, 1, N'($urandom), 0, 0, 0, acc);
        #2;
        rst_i = 1'b1;
        #1;
        check("midreset_ctl", {out_if.valid, rowmax_valid_o, rowmax_o, rowmax_idx_o, overflow_o}, '0);
        check("midreset_data", out_if.data, '0);
        mq.delete(); exp_q.delete(); rq_row.delete(); rq_val.delete();
        m_idx = 0; m_valid = 0; m_ovf = 0;
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;
        run_stream(BEATS, 1'b0, 0, 1'b0, -10);

        for (int i = 0; i < 4; i++) step(0, '0, 0, '0, 0, 1, 0, acc);
        check("beats_drained", W'(exp_q.size()), W'(0));
        check("rowmax_drained", W'(rq_val.size()), W'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ita_mask_apply.md
Name: ita_mask_apply

Overview:
- Downstream consumer of the attention masking stage.
- Buffers the per-beat N-bit masks produced during the final inner tile of the QK step and pairs each mask, in order, with the matching requantized QK output beat.
- Forces masked lanes to the most negative value and forwards the beat over a valid/ready handshake toward softmax.
- Tracks a per-row running maximum across the M/N column groups of a tile and emits it once per completed row.

Parameters:
- N, 16, lanes per beat (power of two)
- M, 64, tile edge; beats per tile = M*M/N, column groups per row = M/N
- WO, 8, signed lane width
- MDEPTH, 4, mask FIFO depth (power of two, >=2)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- clear_i  in  1  synchronous flush: FIFO, beat counter, row maxima, error flag
- mask_en_i  in  1  1: masking active; 0: bypass (lanes unmasked, FIFO unused)
- mask_valid_i  in  1  push strobe for mask_i (one per final-tile QK count)
- mask_i  in  N  bit i=1 -> lane i masked
- valid_i  in  1  input beat valid
- data_i  in  N*WO  input lanes, lane i at [i*WO +: WO], signed
- ready_o  out  1  input beat accepted when valid_i & ready_o
- valid_o  out  1  output beat valid
- data_o  out  N*WO  masked lanes
- ready_i  in  1  downstream ready
- rowmax_valid_o  out  1  one-cycle pulse, row maximum final
- rowmax_o  out  WO  signed row maximum
- rowmax_idx_o  out  log2(M)  row index within tile
- overflow_o  out  1  sticky: mask pushed while FIFO full and not popping

Behaviour:
- Reset (async, rst_i=1) values:
  - valid_o, rowmax_valid_o, overflow_o = 0
  - data_o, rowmax_o, rowmax_idx_o = 0
  - FIFO empty; beat counter 0; row maxima 0
- Mask FIFO, MDEPTH entries x N bits, in-order:
  - Push on mask_valid_i.
  - Pop on each accepted input beat when mask_en_i=1.
  - Full with push and pop in the same cycle: push accepted, occupancy unchanged.
  - Full with push and no pop: mask dropped, overflow_o set until clear_i or reset.
  - No same-cycle bypass: a mask pushed in cycle t is usable from t+1.
  - With mask_en_i=0, pushes still fill the FIFO; no pops occur.
- ready_o = (~mask_en_i | fifo_nonempty) & (~valid_o | ready_i).
  - ready_o is combinational from state and ready_i only; it never depends on valid_i.
- Output register, latency 1:
  - On accept: valid_o=1 next cycle; lane i = (mask_en_i & head[i]) ? -2^(WO-1) : data_i lane i.
  - valid_o=1 & ready_i=0: data_o and valid_o hold stable.
  - valid_o=1 & ready_i=1 with no new accept: valid_o drops to 0.
  - Back-to-back throughput: 1 beat/cycle.
- Beat counter idx, 0..M*M/N-1:
  - Increments on each input accept; wraps to 0 after M*M/N-1.
  - row = idx & (M-1); group = idx / M.
- Row max:
  - bmax = signed max of the post-mask lanes of the accepted beat.
  - rmax[row] <= (group==0) ? bmax : max(rmax[row], bmax).
  - When group==M/N-1, in the same cycle the output beat becomes valid: rowmax_valid_o=1, rowmax_o = final max, rowmax_idx_o = row.
  - rowmax pulse is not gated by ready_i; it fires once per row regardless of output stall.
  - Fully masked row reports -2^(WO-1).
- clear_i:
  - Empties the FIFO, zeroes idx, clears overflow_o, drops valid_o and rowmax_valid_o next cycle.
  - Priority over a same-cycle push or accept; both are discarded.
- Reset mid-tile: everything returns to reset values immediately; the partial tile is lost.
- Arithmetic:
  - All comparisons are signed WO-bit.
  - Masking substitutes the constant; no widening.

Test Plan:
- Bypass: mask_en_i=0, 256 beats with lane i = i-8 -> data_o equals data_i, latency 1. rowmax_valid_o pulses 64 times (beats 192..255), rowmax_o=7, rowmax_idx_o=0..63.
- Upper-triangular mask:
  - Push 256 masks with mask[i] = (group*16+i > row); feed data all 0x05.
  - Masked lanes output 0x80 (-128).
  - Row 0 max=5; row 63 max=5 (cols 0..63 all <= 63 unmasked).
- Fully masked row:
  - Rows with mask=all ones across all 4 groups -> rowmax_o=-128 for that row.
  - Mixed row with one unmasked lane = -3, all others masked -> rowmax_o=-3.
- Mask FIFO starvation/overflow:
  - valid_i=1 with FIFO empty -> ready_o=0 until a push, then accept one cycle later.
  - 5 pushes with no pops at MDEPTH=4 -> overflow_o=1; clear_i -> overflow_o=0, FIFO empty.
- Backpressure: hold ready_i=0 for 3 cycles mid-stream -> data_o stable, ready_o=0, no beat lost or duplicated. Beat order and idx wrap at 255->0 verified.
- Async reset asserted mid-tile (idx=100) -> outputs 0 immediately. After release, first accepted beat is treated as idx 0, group 0.
